// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: turns the memory-stage controls into a req/ack
// transaction, stalls the pipeline while it is outstanding, and returns extended
// load data along with misalignment and timeout pulses.
module dmem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        acc_valid,
   input  logic        flush,
   input  logic        dmem_sel,
   input  logic [1:0]  w_sel,
   input  logic [2:0]  r_sel,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic        ld_valid,
   output logic [31:0] ld_data,
   output logic        misalign_err,
   output logic        bus_err
);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   // Counter value seen in the last request cycle before giving up.
   localparam logic [7:0] LastCnt = 8'(TIMEOUT_CYC - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        is_load_q, is_load_d;
   logic [2:0]  rsel_q, rsel_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] ld_data_q, ld_data_d;
   logic        ld_valid_q, ld_valid_d;
   logic        misalign_q, misalign_d;
   logic        bus_err_q, bus_err_d;

   logic        is_load, is_store, is_half, is_word, misalign, start;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;
   logic [31:0] shifted, ld_ext;

   // Decode the incoming access, its alignment and lane placement.
   always_comb begin
      is_load   = !dmem_sel && (r_sel inside {3'b000, 3'b010, 3'b011, 3'b100, 3'b101});
      is_store  = dmem_sel && (w_sel != 2'b11);
      is_half   = is_store ? (w_sel == 2'b01) : (r_sel == 3'b010 || r_sel == 3'b101);
      is_word   = is_store ? (w_sel == 2'b10) : (r_sel == 3'b011);
      misalign  = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
      start     = (state_q == StIdle) && acc_valid && !flush && (is_load || is_store);
      stall     = start || (state_q == StBusy);
      be_new    = 4'b1111;
      wdata_new = wdata;
      if (is_store) begin
         unique case (w_sel)
            2'b00: begin
               be_new    = 4'b0001 << addr[1:0];
               wdata_new = {4{wdata[7:0]}};
            end
            2'b01: begin
               be_new    = addr[1] ? 4'b1100 : 4'b0011;
               wdata_new = {2{wdata[15:0]}};
            end
            default: begin
               be_new    = 4'b1111;
               wdata_new = wdata;
            end
         endcase
      end
   end

   // Align the returned word to the addressed lane and extend it.
   always_comb begin
      shifted = mem_rdata >> {off_q, 3'b000};
      unique case (rsel_q)
         3'b000:  ld_ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b010:  ld_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  ld_ext = {24'h0, shifted[7:0]};
         3'b101:  ld_ext = {16'h0, shifted[15:0]};
         default: ld_ext = mem_rdata;
      endcase
   end

   // Sequencer next-state and registered output updates.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      is_load_d   = is_load_q;
      rsel_d      = rsel_q;
      off_d       = off_q;
      ld_data_d   = ld_data_q;
      ld_valid_d  = 1'b0;
      misalign_d  = 1'b0;
      bus_err_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (misalign) begin
                  state_d    = StResp;
                  misalign_d = 1'b1;
               end else begin
                  state_d     = StBusy;
                  cnt_d       = 8'd0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = is_store;
                  mem_be_d    = be_new;
                  mem_addr_d  = {addr[31:2], 2'b00};
                  mem_wdata_d = wdata_new;
                  is_load_d   = is_load;
                  rsel_d      = r_sel;
                  off_d       = addr[1:0];
               end
            end
         end
         StBusy: begin
            cnt_d = cnt_q + 8'd1;
            // An ack in the final counted cycle still completes normally.
            if (mem_ack) begin
               state_d   = StResp;
               mem_req_d = 1'b0;
               if (is_load_q) begin
                  ld_valid_d = 1'b1;
                  ld_data_d  = ld_ext;
               end
            end else if (cnt_q == LastCnt) begin
               state_d   = StResp;
               mem_req_d = 1'b0;
               bus_err_d = 1'b1;
               ld_data_d = 32'h0;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= 8'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 4'b0000;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         is_load_q   <= 1'b0;
         rsel_q      <= 3'b111;
         off_q       <= 2'b00;
         ld_data_q   <= 32'h0;
         ld_valid_q  <= 1'b0;
         misalign_q  <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         is_load_q   <= is_load_d;
         rsel_q      <= rsel_d;
         off_q       <= off_d;
         ld_data_q   <= ld_data_d;
         ld_valid_q  <= ld_valid_d;
         misalign_q  <= misalign_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_be       = mem_be_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign ld_valid     = ld_valid_q;
   assign ld_data      = ld_data_q;
   assign misalign_err = misalign_q;
   assign bus_err      = bus_err_q;

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencer between the pipeline's memory stage and a multi-cycle data memory. It takes the decoded memory controls (`dmem_sel`, `w_sel`, `r_sel`), address and store data for the instruction in the memory stage. It drives a req/ack memory handshake with byte enables and lane-aligned write data, stalls the pipeline while the access is outstanding, and returns sign- or zero-extended load data. It also flags misaligned accesses and memory timeouts.

## Interface
- `TIMEOUT_CYC`, default 255: maximum number of `mem_req` cycles without `mem_ack` before the access is abandoned (1..255).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `acc_valid` input 1: memory-stage instruction is valid. Held stable by the pipeline while `stall`=1.
- `flush` input 1: kill the memory-stage instruction. Honoured only in IDLE.
- `dmem_sel` input 1: 1 = store, 0 = not a store.
- `w_sel` input 2: store size. 00 = SB, 01 = SH, 10 = SW, 11 = none.
- `r_sel` input 3: load type. 000 = LB, 010 = LH, 011 = LW, 100 = LBU, 101 = LHU, 111 = none. Other codes are treated as none.
- `addr` input 32: effective address.
- `wdata` input 32: store source register value.
- `mem_req` output 1: memory request, held until `mem_ack`.
- `mem_we` output 1: 1 = write.
- `mem_be` output 4: byte enables.
- `mem_addr` output 32: word address; `addr[31:2]` followed by 2'b00.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_ack` input 1: access complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` input 32: read word.
- `stall` output 1: freeze the pipeline.
- `ld_valid` output 1: single-cycle pulse; `ld_data` is valid.
- `ld_data` output 32: extended load result.
- `misalign_err` output 1: single-cycle pulse.
- `bus_err` output 1: single-cycle pulse on timeout.

## Operation
- An instruction is a load when `dmem_sel`=0 and `r_sel` is a valid load code. It is a store when `dmem_sel`=1 and `w_sel`≠11.
- `start` = IDLE & `acc_valid` & ~`flush` & (load | store).
- Misaligned means: any halfword access with `addr[0]`=1, or any word access with `addr[1:0]`≠00.
- States:
  - IDLE → BUSY on `start` when aligned. The block latches `mem_addr`, `mem_we`, `mem_be`, `mem_wdata`, the load type and `addr[1:0]`, and clears the timeout counter.
  - IDLE → RESP on `start` when misaligned. `misalign_err` pulses in RESP and no memory request is made.
  - BUSY: `mem_req`=1 and the counter increments each cycle.
    - On `mem_ack`, go to RESP and capture `mem_rdata`.
    - If the counter reaches `TIMEOUT_CYC` without `mem_ack`, go to RESP, drop `mem_req`, and pulse `bus_err`. The captured data is 0.
  - RESP: `stall`=0. `ld_valid`=1 for one cycle only for a completed, aligned load. Then go to IDLE unconditionally, ignoring `acc_valid` that cycle.
- `stall` = (IDLE & `start`) | BUSY. This is combinational, so the pipeline is held from the acceptance cycle onward.
- Byte enables and write data:
  - SB: `mem_be` = 0001 shifted left by `addr[1:0]`; `mem_wdata` = `wdata[7:0]` replicated ×4.
  - SH: `mem_be` = 0011 shifted left by 2×`addr[1]`; `mem_wdata` = `wdata[15:0]` replicated ×2.
  - SW: `mem_be` = 1111; `mem_wdata` = `wdata`.
  - Loads: `mem_be` = 1111 and `mem_we`=0.
- Load extraction: shift the captured word right by 8×`addr[1:0]`.
  - LB/LH: sign-extend bit 7 or bit 15.
  - LBU/LHU: zero-extend.
  - LW: pass unmodified.
- `flush` or `acc_valid` changing while in BUSY does not abort the access. The transaction always completes or times out.
- If `mem_ack` arrives in the same cycle the counter reaches `TIMEOUT_CYC`, `mem_ack` wins and no `bus_err` is raised.
- A `mem_ack` received outside BUSY is ignored.

## Timing
- Reset values: state IDLE, `mem_req`/`mem_we`=0, `mem_be`=0, `mem_addr`/`mem_wdata`=0, `ld_valid`/`misalign_err`/`bus_err`=0, `ld_data`=0, counter 0.
- `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` and `ld_data` are registered. `stall` is combinational.
- Best case is `mem_ack` in the first request cycle:
  - T0: accept, `stall`=1.
  - T1: BUSY, `mem_req`=1, `mem_ack`=1, `stall`=1.
  - T2: RESP, `ld_valid`=1, `stall`=0.
  - Stall lasts 2 cycles.
- Each cycle of memory wait adds one stall cycle.
- Timeout: `bus_err` is asserted in the cycle after the `TIMEOUT_CYC`-th request cycle. Total stall is `TIMEOUT_CYC`+1 cycles.
- Misaligned access: stall for 1 cycle (T0), with `misalign_err` in T1.
- Asserting `rst_n` mid-access immediately drops `mem_req` and returns to IDLE. The outstanding access is discarded.

## Test plan
- LB at `addr`=0x1003, `mem_rdata`=0x80112233, ack in the first cycle → `mem_be`=1111, `ld_valid` at T2, `ld_data`=0xFFFFFF80, `stall` high for exactly 2 cycles.
- SH at `addr`=0x2002, `wdata`=0xDEADBEEF, ack after 3 wait cycles → `mem_be`=1100, `mem_wdata`=0xBEEFBEEF, `mem_we`=1, `stall` high for 5 cycles, no `ld_valid`.
- LW at `addr`=0x0006 → no `mem_req`, `misalign_err` pulse at T1, `stall` high 1 cycle. LHU at 0x0006 with `mem_rdata`=0x9ABC0000 → `ld_data`=0x00009ABC.
- LW with `mem_ack` never asserted and `TIMEOUT_CYC`=4 → `mem_req` high 4 cycles, then `bus_err` pulse, `ld_valid`=0, state back to IDLE.
- `flush`=1 with a valid SW in IDLE → no request, no stall. `flush` raised during BUSY → access still completes on ack.
- `rst_n` pulled low while in BUSY → `mem_req`=0 asynchronously. After release, a new LBU at 0x01 with `mem_rdata`=0x0000F000 → `ld_data`=0x000000F0.
